// File: rtl/emulador_hcsr04_pkg.sv
// emulador_hcsr04_pkg: FSM state codes, default HC-SR04 timing at 50 MHz, BCD digit limit and a max helper
package emulador_hcsr04_pkg;
  localparam logic [2:0] INICIAL   = 3'd0;
  localparam logic [2:0] MEDE_TRIG = 3'd1;
  localparam logic [2:0] ATRASO    = 3'd2;
  localparam logic [2:0] ECO       = 3'd3;
  localparam logic [2:0] RECUPERA  = 3'd4;
  localparam int D_CLK_POR_CM  = 2941;
  localparam int D_TRIG_MIN    = 500;
  localparam int D_ATRASO_ECO  = 10000;
  localparam int D_DIST_MAX    = 400;
  localparam int D_ECO_TIMEOUT = 1900000;
  localparam int D_HOLDOFF     = 500;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic int maximo(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/emulador_hcsr04_conversor_bcd_bin.sv
// conversor_bcd_bin: combinational BCD i_bcd[11:0] to binary o_bin[8:0], o_valido when every digit <= 9 and 1 <= value <= DIST_MAX
module conversor_bcd_bin import emulador_hcsr04_pkg::*; #(
  parameter int DIST_MAX = D_DIST_MAX
) (
  input  logic [11:0] i_bcd,
  output logic [8:0]  o_bin,
  output logic        o_valido
);
  logic [9:0] w_d;
  logic       w_dig_ok;
  assign w_d      = 10'(i_bcd[11:8]) * 10'd100 + 10'(i_bcd[7:4]) * 10'd10 + 10'(i_bcd[3:0]);
  assign w_dig_ok = (i_bcd[11:8] <= BCD_MAX) && (i_bcd[7:4] <= BCD_MAX) && (i_bcd[3:0] <= BCD_MAX);
  assign o_valido = w_dig_ok && (w_d != 10'd0) && (w_d <= 10'(DIST_MAX));
  assign o_bin    = w_d[8:0];
endmodule

// File: rtl/emulador_hcsr04.sv
// emulador_hcsr04: HC-SR04 responder; in clock, reset, trigger, distancia[11:0] BCD; out eco, ocupado, erro_trigger, plus db_estado[3:0] under DB_ESTADO_EN
module emulador_hcsr04 import emulador_hcsr04_pkg::*; #(
  parameter int CLK_POR_CM  = D_CLK_POR_CM,
  parameter int TRIG_MIN    = D_TRIG_MIN,
  parameter int ATRASO_ECO  = D_ATRASO_ECO,
  parameter int DIST_MAX    = D_DIST_MAX,
  parameter int ECO_TIMEOUT = D_ECO_TIMEOUT,
  parameter int HOLDOFF     = D_HOLDOFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trigger,
  input  logic [11:0] distancia,
  output logic        eco,
  output logic        ocupado,
`ifdef DB_ESTADO_EN
  output logic        erro_trigger,
  output logic [3:0]  db_estado
`else
  output logic        erro_trigger
`endif
);
  localparam int LARG_MAX = maximo(DIST_MAX * CLK_POR_CM, ECO_TIMEOUT);
  localparam int LW = $clog2(LARG_MAX + 1);
  localparam int CW = $clog2(maximo(LARG_MAX, maximo(TRIG_MIN, maximo(ATRASO_ECO, HOLDOFF))) + 1);
  localparam logic [CW-1:0] TRIG_C   = CW'(TRIG_MIN);
  localparam logic [CW-1:0] ATRASO_C = CW'(ATRASO_ECO);
  localparam logic [CW-1:0] HOLD_C   = CW'(HOLDOFF);
  logic [2:0]    r_estado;
  logic [CW-1:0] r_cnt, w_cnt_inc;
  logic [LW-1:0] r_largura, w_largura;
  logic [8:0]    w_bin;
  logic          w_valido, r_eco, r_ocupado, r_erro;
  conversor_bcd_bin #(.DIST_MAX(DIST_MAX)) u_conv (
    .i_bcd   (distancia),
    .o_bin   (w_bin),
    .o_valido(w_valido)
  );
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_largura = w_valido ? LW'(w_bin) * LW'(CLK_POR_CM) : LW'(ECO_TIMEOUT);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado  <= INICIAL;
      r_cnt     <= '0;
      r_largura <= '0;
      r_eco     <= 1'b0;
      r_ocupado <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_erro <= 1'b0;
      case (r_estado)
        INICIAL:
          if (trigger) begin
            r_estado <= MEDE_TRIG;
            r_cnt    <= CW'(1);
          end
        MEDE_TRIG:
          if (trigger) r_cnt <= (r_cnt >= TRIG_C) ? r_cnt : w_cnt_inc;
          else if (r_cnt >= TRIG_C) begin
            r_estado  <= ATRASO;
            r_cnt     <= '0;
            r_largura <= w_largura;
            r_ocupado <= 1'b1;
          end else begin
            r_estado <= INICIAL;
            r_cnt    <= '0;
            r_erro   <= 1'b1;
          end
        ATRASO:
          if (w_cnt_inc == ATRASO_C) begin
            r_estado <= ECO;
            r_cnt    <= '0;
            r_eco    <= 1'b1;
          end else r_cnt <= w_cnt_inc;
        ECO:
          if (w_cnt_inc == CW'(r_largura)) begin
            r_estado <= RECUPERA;
            r_cnt    <= '0;
            r_eco    <= 1'b0;
          end else r_cnt <= w_cnt_inc;
        RECUPERA:
          if (w_cnt_inc == HOLD_C) begin
            r_estado  <= INICIAL;
            r_cnt     <= '0;
            r_ocupado <= 1'b0;
          end else r_cnt <= w_cnt_inc;
        default: begin
          r_estado <= INICIAL;
          r_cnt    <= '0;
        end
      endcase
    end
  end
  assign eco          = r_eco;
  assign ocupado      = r_ocupado;
  assign erro_trigger = r_erro;
`ifdef DB_ESTADO_EN
  assign db_estado = {1'b0, r_estado};
`endif
endmodule

// File: tb/tb_emulador_hcsr04.sv
// tb_emulador_hcsr04: scoreboard bench for emulador_hcsr04 with shortened timing parameters
module tb_emulador_hcsr04;
  localparam int CPC  = 7;
  localparam int TMIN = 5;
  localparam int ATR  = 20;
  localparam int DMAX = 400;
  localparam int TO   = 3000;
  localparam int HO   = 6;
  logic clock = 0, reset = 1, trigger = 0;
  logic [11:0] distancia = '0;
  logic eco, ocupado, erro_trigger;
`ifdef DB_ESTADO_EN
  logic [3:0] db_estado;
`endif
  int n_cmp = 0, n_err = 0;
  int esp[$];
  int ciclo = 0, n_fall = 0, n_rise = 0, n_desce = 0, n_erro = 0, n_ecos = 0;
  bit ignora = 0, espera_hold = 0;
  logic eco_ant = 0, ocup_ant = 0, trig_ant = 0;
  always #5 clock = ~clock;
  emulador_hcsr04 #(
    .CLK_POR_CM(CPC), .TRIG_MIN(TMIN), .ATRASO_ECO(ATR),
    .DIST_MAX(DMAX), .ECO_TIMEOUT(TO), .HOLDOFF(HO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .trigger     (trigger),
    .distancia   (distancia),
    .eco         (eco),
    .ocupado     (ocupado),
`ifdef DB_ESTADO_EN
    .erro_trigger(erro_trigger),
    .db_estado   (db_estado)
`else
    .erro_trigger(erro_trigger)
`endif
  );
  task automatic verifica(input string tag, input int obs, input int req);
    n_cmp++;
    if (obs != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, req);
    end
  endtask
  function automatic int largura_esperada(input logic [11:0] d);
    int h, t, u, v;
    h = int'(d[11:8]);
    t = int'(d[7:4]);
    u = int'(d[3:0]);
    v = h * 100 + t * 10 + u;
    if (h > 9 || t > 9 || u > 9 || v == 0 || v > DMAX) return TO;
    return v * CPC;
  endfunction
  always @(negedge clock) begin
    ciclo++;
    if (trig_ant && !trigger && !ocupado) n_fall = ciclo;
    if (!eco_ant && eco) begin
      n_rise = ciclo;
      n_ecos++;
      verifica("eco_esperado", int'(esp.size() > 0), 1);
    end
    if (eco_ant && !eco) begin
      if (ignora) ignora = 0;
      else if (esp.size() > 0) begin
        verifica("atraso", n_rise - n_fall - 1, ATR);
        verifica("largura", ciclo - n_rise, esp.pop_front());
        n_desce = ciclo;
        espera_hold = 1;
      end
    end
    if (espera_hold && ocup_ant && !ocupado) begin
      verifica("holdoff", ciclo - n_desce, HO);
      espera_hold = 0;
    end
    if (erro_trigger) n_erro++;
    eco_ant = eco;
    ocup_ant = ocupado;
    trig_ant = trigger;
  end
  task automatic pulso(input int n);
    trigger = 1;
    repeat (n) @(posedge clock);
    #1 trigger = 0;
  endtask
  task automatic disparo(input int n, input logic [11:0] d, input bit aceito);
    distancia = d;
    if (aceito) esp.push_back(largura_esperada(d));
    pulso(n);
  endtask
  task automatic espera_ocupado(input logic v, input string tag);
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      if (ocupado == v) return;
    end
    verifica(tag, ocupado, v);
  endtask
  task automatic espera_eco(input logic v);
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      if (eco == v) return;
    end
    verifica("timeout_eco", eco, v);
  endtask
  task automatic espera_livre();
    espera_ocupado(1'b1, "timeout_ocupa");
    espera_ocupado(1'b0, "timeout_libera");
    @(posedge clock);
    #1;
  endtask
  logic [11:0] tabela [6] = '{12'h401, 12'h0A3, 12'h000, 12'h400, 12'h399, 12'h00F};
  initial begin
    int e0, c0, lixo;
    bit oc_visto;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    verifica("rst_eco", eco, 0);
    verifica("rst_ocupado", ocupado, 0);
    verifica("rst_erro", erro_trigger, 0);
`ifdef DB_ESTADO_EN
    verifica("rst_estado", db_estado, 0);
`endif
    @(posedge clock);
    #1;
    disparo(TMIN, 12'h005, 1);
    espera_livre();
    e0 = n_erro;
    c0 = n_ecos;
    oc_visto = 0;
    disparo(TMIN - 1, 12'h005, 0);
    repeat (ATR + 10) begin
      @(negedge clock);
      if (ocupado) oc_visto = 1;
    end
    verifica("erro_pulso", n_erro - e0, 1);
    verifica("erro_sem_eco", n_ecos - c0, 0);
    verifica("erro_ocupado", int'(oc_visto), 0);
    @(posedge clock);
    #1;
    disparo(TMIN + 7, 12'h123, 1);
    espera_livre();
    foreach (tabela[i]) begin
      disparo(TMIN, tabela[i], 1);
      espera_livre();
    end
    e0 = n_erro;
    c0 = n_ecos;
    disparo(TMIN, 12'h010, 1);
    espera_eco(1'b1);
    @(posedge clock);
    #1 distancia = 12'h300;
    repeat (3) @(posedge clock);
    #1;
    pulso(8);
    repeat (3) @(posedge clock);
    #1;
    pulso(2);
    espera_ocupado(1'b0, "timeout_libera");
    repeat (ATR + 20) @(posedge clock);
    #1;
    verifica("ignora_ecos", n_ecos - c0, 1);
    verifica("ignora_erro", n_erro - e0, 0);
    disparo(TMIN, 12'h020, 1);
    espera_eco(1'b1);
    @(posedge clock);
    repeat (49) @(posedge clock);
    #1 reset = 1;
    lixo = esp.pop_front();
    ignora = 1;
    @(posedge clock);
    @(negedge clock);
    verifica("rst_eco_meio", eco, 0);
    verifica("rst_ocupado_meio", ocupado, 0);
    @(posedge clock);
    #1 reset = 0;
    disparo(TMIN, 12'h001, 1);
    espera_livre();
    disparo(TMIN, 12'h005, 1);
    espera_eco(1'b1);
    espera_eco(1'b0);
    repeat (HO - 1) @(posedge clock);
    #1;
    disparo(TMIN + 1, 12'h005, 1);
    espera_livre();
    verifica("fila_vazia", esp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/emulador_hcsr04.md
Name: emulador_hcsr04

Overview:
Behavioural responder for the HC-SR04 ultrasonic sensor protocol, synthesizable for FPGA. It receives the trigger pulse produced by our interface block and answers with an echo pulse whose width encodes a programmed BCD distance, at 50 MHz. It is used on-board and in benches as a stand-in for the physical sensor, so the trena datapath can be exercised without hardware.

Parameters:
CLK_POR_CM, 2941, echo clocks per centimetre (58.82 us at 50 MHz)
TRIG_MIN, 500, minimum trigger high width in clocks (10 us)
ATRASO_ECO, 10000, clocks from trigger fall to echo rise (200 us burst time)
DIST_MAX, 400, largest valid distance in cm
ECO_TIMEOUT, 1900000, echo width in clocks for no-target / invalid distance (38 ms)
HOLDOFF, 500, dead time in clocks after echo fall before the next trigger is accepted

Ports:
clock  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
trigger  input  1  trigger from initiator; synchronous to clock, no synchronizer
distancia  input  12  distance in BCD, [11:8] hundreds, [7:4] tens, [3:0] units
eco  output  1  echo pulse to initiator
ocupado  output  1  high from accepted trigger until end of HOLDOFF
erro_trigger  output  1  one-clock pulse when a trigger shorter than TRIG_MIN ends

Behaviour:
- One clock; reset is synchronous and active-high. Reset forces state INICIAL, eco=0, ocupado=0, erro_trigger=0, all counters=0 on the next edge. This applies in any state, including mid-echo.
- FSM states: INICIAL, MEDE_TRIG, ATRASO, ECO, RECUPERA.
- INICIAL: trigger=1 goes to MEDE_TRIG with the width counter at 1.
- MEDE_TRIG: the counter increments each clock while trigger=1 and saturates at TRIG_MIN. On the first clock with trigger=0:
  - if count >= TRIG_MIN: latch distancia, compute the echo width, go to ATRASO, ocupado=1.
  - otherwise: erro_trigger=1 for exactly one clock, return to INICIAL.
- ATRASO: lasts exactly ATRASO_ECO clocks. eco rises on the edge ATRASO_ECO clocks after the first trigger-low clock.
- ECO: eco=1 for exactly W clocks, then RECUPERA.
  - Valid distance: W = d*CLK_POR_CM, where d = 100*h + 10*t + u.
  - Invalid distance: W = ECO_TIMEOUT. Invalid means any BCD digit >9, d=0, or d>DIST_MAX.
- RECUPERA: HOLDOFF clocks, then INICIAL with ocupado=0.
- Trigger activity in ATRASO, ECO and RECUPERA is ignored entirely: no restart, no erro_trigger.
- A trigger already high on the clock RECUPERA exits is seen in INICIAL and measured from that clock.
- distancia changes after the latch do not affect the current echo.
- Width arithmetic: the echo counter is $clog2(max(DIST_MAX*CLK_POR_CM, ECO_TIMEOUT)+1) bits. The product is computed at full width with no truncation.
- All outputs are registered, with no combinational path from trigger to eco.

Optional Feature:
Macro DB_ESTADO_EN.
- Defined: adds output port db_estado [3:0] carrying the FSM state code, for hexa display on the board. Codes: INICIAL=0, MEDE_TRIG=1, ATRASO=2, ECO=3, RECUPERA=4.
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state encoding constants, default timing constants (CLK_POR_CM, TRIG_MIN, ATRASO_ECO, ECO_TIMEOUT), and the BCD digit-valid limit 9.
- Sub-module conversor_bcd_bin: combinational 12-bit BCD to 9-bit binary converter with a valido flag, instantiated once at the latch point.

Test Plan:
- Reset; trigger high 500 clocks; distancia=0x005 -> eco rises 10000 clocks after trigger fall and stays high 14705 clocks; ocupado drops 500 clocks after eco falls.
- Trigger high 499 clocks -> erro_trigger high exactly 1 clock; eco never rises; ocupado stays 0.
- distancia=0x401, then distancia=0x0A3 (invalid digit), each with a valid trigger -> eco width 1900000 clocks in both cases.
- Valid trigger with distancia=0x010; change distancia to 0x300 and pulse trigger 600 clocks during ECO -> eco width stays 29410 clocks, no second echo, no erro_trigger.
- Assert reset 100 clocks into ECO -> eco=0 and ocupado=0 on the next edge; a following valid trigger with 0x001 gives eco of 2941 clocks.
- Back-to-back: a second valid trigger starting on the RECUPERA exit clock is accepted, and eco timing is the same as in the first scenario.
